imem_fetch_bank: RTL and testbench

Parametrised instruction memory for the single-cycle core's fetch path, successor to the combinational 16-bit instruction bank. Adds a registered read with valid/ready request and response handshakes, a program-load write port, an optional two-word fetch mode that packs consecutive instructions into one response, and out-of-range detection. It sits between the PC/fetch logic and the decoder, and returns instructions zero-extended to the core's 32-bit instruction bus.

---
 rtl/imem_fetch_bank_pkg.sv | 13 +
 rtl/imem_fetch_bank_if.sv | 27 ++
 rtl/imem_rsp_fifo.sv | 40 ++++
 rtl/imem_fetch_bank.sv | 61 ++++++
 tb/tb_imem_fetch_bank.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_bank_pkg.sv
// imem_pkg: shared defaults, fetch-mode encodings and the response record for the instruction bank.
package imem_pkg;
  localparam int IMEM_DATA_W = 16;
  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DEPTH = 256;
  localparam int IMEM_OUT_W = 32;
  localparam int FETCH_SINGLE = 1;
  localparam int FETCH_PAIR = 2;
  typedef struct packed {
    logic err;
    logic [IMEM_OUT_W-1:0] data;
  } imem_rsp_t;
endpackage

// File: rtl/imem_fetch_bank_if.sv
// imem_fetch_bank_if: fetch request/response handshakes plus the program-load port.
interface imem_fetch_bank_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int OUT_W = IMEM_OUT_W
) ();
  logic req_valid;
  logic req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic rsp_valid;
  logic rsp_ready;
  logic [OUT_W-1:0] rsp_data;
  logic rsp_err;
  logic ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    input req_ready, rsp_valid, rsp_data, rsp_err
  );
  modport slave (
    input req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: two-entry response queue; entry 0 is always the head.
module imem_rsp_fifo #(
  parameter int W = 33
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic [1:0] count,
  output logic valid
);
  logic [W-1:0] e0, e1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0 <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          e0 <= count == 2'd1 ? din : e1;
          e1 <= din;
        end
        default: ;
      endcase
    end
  assign dout = e0;
  assign valid = count != 2'd0;
endmodule

// File: rtl/imem_fetch_bank.sv
// imem_fetch_bank: loadable instruction array with a registered read stage feeding a 2-deep response FIFO.
module imem_fetch_bank
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH = IMEM_DEPTH,
  parameter int OUT_W = IMEM_OUT_W,
  parameter int FETCH_WORDS = FETCH_SINGLE
) (
  input logic clk,
  input logic rst_n,
  imem_fetch_bank_if.slave bus
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  typedef struct packed {
    logic err;
    logic [OUT_W-1:0] data;
  } rsp_t;
  logic [DATA_W-1:0] mem [DEPTH];
  logic s1_valid, in_range, pop, accept, fifo_valid;
  logic [ADDR_W-1:0] nxt;
  logic [2*DATA_W-1:0] pair;
  logic [1:0] count;
  logic [2:0] occ;
  rsp_t rd, s1, head;
  always_ff @(posedge clk)
    if (bus.ld_en && {1'b0, bus.ld_addr} < DEPTH_L) mem[bus.ld_addr[IDX_W-1:0]] <= bus.ld_data;
  // The pair's upper word wraps to word 0 instead of flagging an error.
  assign in_range = {1'b0, bus.req_addr} < DEPTH_L;
  assign nxt = bus.req_addr == LAST ? '0 : bus.req_addr + ADDR_W'(1);
  assign pair = {FETCH_WORDS == FETCH_PAIR ? mem[nxt[IDX_W-1:0]] : {DATA_W{1'b0}},
                 mem[bus.req_addr[IDX_W-1:0]]};
  assign rd.err = !in_range;
  assign rd.data = in_range ? OUT_W'(pair) : '0;
  // Loads and fetches never share an edge, so a fetch always sees the latest load.
  assign pop = fifo_valid && bus.rsp_ready;
  assign occ = 3'(count) + 3'(s1_valid) - 3'(pop);
  assign bus.req_ready = rst_n && !bus.ld_en && occ < 3'd2;
  assign accept = bus.req_valid && bus.req_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s1_valid <= 1'b0;
    else s1_valid <= accept;
  always_ff @(posedge clk)
    if (accept) s1 <= rd;
  imem_rsp_fifo #(.W($bits(rsp_t))) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(s1_valid),
    .din(s1),
    .pop(pop),
    .dout(head),
    .count(count),
    .valid(fifo_valid)
  );
  assign bus.rsp_valid = fifo_valid;
  assign bus.rsp_data = head.data;
  assign bus.rsp_err = head.err;
endmodule

// File: tb/tb_imem_fetch_bank.sv
// tb_imem_fetch_bank: directed checks of a single-word bank and a pair-mode bank, both 16 words deep.
module tb_imem_fetch_bank;
  import imem_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  imem_fetch_bank_if #(.ADDR_W(8), .DATA_W(16), .OUT_W(32)) b1 ();
  imem_fetch_bank_if #(.ADDR_W(8), .DATA_W(16), .OUT_W(32)) b2 ();
  imem_fetch_bank #(.DATA_W(16), .ADDR_W(8), .DEPTH(16), .OUT_W(32), .FETCH_WORDS(FETCH_SINGLE))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  imem_fetch_bank #(.DATA_W(16), .ADDR_W(8), .DEPTH(16), .OUT_W(32), .FETCH_WORDS(FETCH_PAIR))
    u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_both(input logic [7:0] a, input logic [15:0] d);
    b1.ld_en = 1'b1; b1.ld_addr = a; b1.ld_data = d;
    b2.ld_en = 1'b1; b2.ld_addr = a; b2.ld_data = d;
    tick;
    b1.ld_en = 1'b0;
    b2.ld_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    b1.req_valid = 1'b0; b1.req_addr = '0; b1.rsp_ready = 1'b0;
    b1.ld_en = 1'b0; b1.ld_addr = '0; b1.ld_data = '0;
    b2.req_valid = 1'b0; b2.req_addr = '0; b2.rsp_ready = 1'b0;
    b2.ld_en = 1'b0; b2.ld_addr = '0; b2.ld_data = '0;
    tick;
    tick;
    checks++; if (b1.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", b1.req_ready); end
    checks++; if (b1.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", b1.rsp_valid); end
    checks++; if (b1.rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data got %h exp 0", b1.rsp_data); end
    checks++; if (b1.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b exp 0", b1.rsp_err); end
    rst_n = 1'b1;
    #1;
    checks++; if (b1.req_ready !== 1'b1) begin errors++; $display("FAIL rel_req_ready got %b exp 1", b1.req_ready); end
    tick;
  endtask

  task automatic preload;
    load_both(8'd0, 16'h0008);
    load_both(8'd1, 16'h7280);
    load_both(8'd2, 16'h1102);
    load_both(8'd3, 16'h1103);
    load_both(8'd4, 16'h1104);
    load_both(8'd5, 16'h1105);
    load_both(8'd15, 16'hABCD);
  endtask

  task automatic test_latency;
    b1.req_valid = 1'b1; b1.req_addr = 8'd0;
    #1;
    checks++; if (b1.req_ready !== 1'b1) begin errors++; $display("FAIL lat_ready got %b exp 1", b1.req_ready); end
    tick;
    b1.req_valid = 1'b0;
    checks++; if (b1.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid got %b exp 0", b1.rsp_valid); end
    tick;
    checks++; if (b1.rsp_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %b exp 1", b1.rsp_valid); end
    checks++; if (b1.rsp_data !== 32'h0000_0008) begin errors++; $display("FAIL lat_data got %h exp 00000008", b1.rsp_data); end
    checks++; if (b1.rsp_err !== 1'b0) begin errors++; $display("FAIL lat_err got %b exp 0", b1.rsp_err); end
    b1.rsp_ready = 1'b1;
    tick;
    b1.rsp_ready = 1'b0;
    checks++; if (b1.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_drain got %b exp 0", b1.rsp_valid); end
  endtask

  task automatic test_pair;
    b2.rsp_ready = 1'b1;
    b2.req_valid = 1'b1; b2.req_addr = 8'd0;
    tick;
    b2.req_addr = 8'd15;
    tick;
    checks++; if (b2.rsp_data !== 32'h7280_0008) begin errors++; $display("FAIL pair_0 got %h exp 72800008", b2.rsp_data); end
    b2.req_addr = 8'd20;
    tick;
    b2.req_valid = 1'b0;
    checks++; if (b2.rsp_data !== 32'h0008_ABCD) begin errors++; $display("FAIL pair_wrap got %h exp 0008abcd", b2.rsp_data); end
    checks++; if (b2.rsp_err !== 1'b0) begin errors++; $display("FAIL pair_wrap_err got %b exp 0", b2.rsp_err); end
    tick;
    checks++; if (b2.rsp_data !== 32'h0 || b2.rsp_err !== 1'b1) begin errors++; $display("FAIL pair_oor got %h/%b exp 0/1", b2.rsp_data, b2.rsp_err); end
    tick;
    b2.rsp_ready = 1'b0;
    checks++; if (b2.rsp_valid !== 1'b0) begin errors++; $display("FAIL pair_drain got %b exp 0", b2.rsp_valid); end
  endtask

  task automatic test_out_of_range;
    load_both(8'd20, 16'hDEAD);
    b1.rsp_ready = 1'b1;
    b1.req_valid = 1'b1; b1.req_addr = 8'd20;
    tick;
    b1.req_addr = 8'd4;
    tick;
    b1.req_valid = 1'b0;
    checks++; if (b1.rsp_data !== 32'h0) begin errors++; $display("FAIL oor_data got %h exp 0", b1.rsp_data); end
    checks++; if (b1.rsp_err !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", b1.rsp_err); end
    tick;
    checks++; if (b1.rsp_data !== 32'h0000_1104 || b1.rsp_err !== 1'b0) begin errors++; $display("FAIL oor_load_ignored got %h/%b exp 00001104/0", b1.rsp_data, b1.rsp_err); end
    tick;
    b1.rsp_ready = 1'b0;
  endtask

  task automatic test_back_pressure;
    logic [15:0] exp_bp [6];
    logic [7:0] a;
    int acc, got;
    exp_bp = '{16'h0008, 16'h7280, 16'h1102, 16'h1103, 16'h1104, 16'h1105};
    a = 8'd0; acc = 0; got = 0;
    b1.rsp_ready = 1'b0;
    b1.req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b1.req_addr = a;
      #1;
      if (b1.req_ready) begin acc++; a++; end
      tick;
    end
    b1.req_addr = a;
    #1;
    checks++; if (acc !== 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", acc); end
    checks++; if (b1.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", b1.req_ready); end
    checks++; if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== 32'h0000_0008) begin errors++; $display("FAIL bp_hold got %b/%h exp 1/00000008", b1.rsp_valid, b1.rsp_data); end
    b1.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && got < 6; i++) begin
      b1.req_valid = a < 8'd6;
      b1.req_addr = a;
      #1;
      if (b1.req_valid && b1.req_ready) a++;
      if (b1.rsp_valid) begin
        checks++;
        if (b1.rsp_data !== {16'h0, exp_bp[got]}) begin errors++; $display("FAIL bp_order[%0d] got %h exp %h", got, b1.rsp_data, {16'h0, exp_bp[got]}); end
        got++;
      end
      tick;
    end
    b1.req_valid = 1'b0;
    checks++; if (got !== 6) begin errors++; $display("FAIL bp_count got %0d exp 6", got); end
    checks++; if (b1.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_extra got %b exp 0", b1.rsp_valid); end
    b1.rsp_ready = 1'b0;
  endtask

  task automatic test_load_priority;
    b1.ld_en = 1'b1; b1.ld_addr = 8'd3; b1.ld_data = 16'hF004;
    b1.req_valid = 1'b1; b1.req_addr = 8'd3;
    #1;
    checks++; if (b1.req_ready !== 1'b0) begin errors++; $display("FAIL ld_prio_ready got %b exp 0", b1.req_ready); end
    tick;
    b1.ld_en = 1'b0;
    #1;
    checks++; if (b1.req_ready !== 1'b1) begin errors++; $display("FAIL ld_after_ready got %b exp 1", b1.req_ready); end
    tick;
    b1.req_valid = 1'b0;
    tick;
    checks++; if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== 32'h0000_F004) begin errors++; $display("FAIL raw_data got %b/%h exp 1/0000f004", b1.rsp_valid, b1.rsp_data); end
    b1.rsp_ready = 1'b1;
    tick;
    b1.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    b1.rsp_ready = 1'b0;
    b1.req_valid = 1'b1; b1.req_addr = 8'd4;
    tick;
    b1.req_addr = 8'd5;
    tick;
    b1.req_valid = 1'b0;
    tick;
    checks++; if (b1.rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_queued got %b exp 1", b1.rsp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (b1.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", b1.rsp_valid); end
    checks++; if (b1.req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", b1.req_ready); end
    tick;
    rst_n = 1'b1;
    b1.req_valid = 1'b1; b1.req_addr = 8'd1;
    tick;
    b1.req_valid = 1'b0;
    checks++; if (b1.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale got %b exp 0", b1.rsp_valid); end
    tick;
    checks++; if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== 32'h0000_7280) begin errors++; $display("FAIL mid_retained got %b/%h exp 1/00007280", b1.rsp_valid, b1.rsp_data); end
    b1.rsp_ready = 1'b1;
    tick;
    b1.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    preload;
    test_latency;
    test_pair;
    test_out_of_range;
    test_back_pressure;
    test_load_priority;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
